fall_alarm_responder: RTL and testbench

//   Caregiver-side responder for the fall-detection alarm. Consumes the level

---
 rtl/fall_alarm_responder.sv | 171 +++++++++++++++++
 tb/tb_fall_alarm_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fall_alarm_responder.sv
// Fall-alarm responder: patterned buzzer, nurse-call req/ack with timeout escalation, caregiver clear pulse.
// Latency: 1 cycle from alarm_in/call_ack/caregiver_clear to registered outputs. Optional call_count via FALL_RESP_COUNT_EN.
// Backpressure: none; call_req is held until call_ack or ACK_TIMEOUT, then dropped for one guaranteed gap cycle.
module fall_alarm_responder #(
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_LEVEL   = 3,
    parameter int BEEP_ON     = 4,
    parameter int BEEP_OFF    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       call_ack,
    input  logic       caregiver_clear,
    output logic       call_req,
    output logic [1:0] call_level,
    output logic       escalated,
    output logic       buzzer,
    output logic       clear_out,
    output logic       busy
`ifdef FALL_RESP_COUNT_EN
    ,
    output logic [7:0] call_count
`endif
);

    localparam int TW          = $clog2(ACK_TIMEOUT);
    localparam int BEEP_PERIOD = BEEP_ON + BEEP_OFF;
    localparam int PW          = $clog2(BEEP_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NOTIFY,
        S_ESCALATE,
        S_WAIT_CLEAR,
        S_CLEAR
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          beep_nxt;

    // Beep phase free-runs for the whole event; buzzer is high for the first BEEP_ON phases.
    always_comb begin
        phase_nxt = (phase == PW'(BEEP_PERIOD - 1)) ? '0 : phase + 1'b1;
        beep_nxt  = (phase_nxt < PW'(BEEP_ON));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            phase      <= '0;
            call_req   <= 1'b0;
            call_level <= 2'd0;
            escalated  <= 1'b0;
            buzzer     <= 1'b0;
            clear_out  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            clear_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alarm_in) begin
                        state      <= S_NOTIFY;
                        call_req   <= 1'b1;
                        call_level <= 2'd0;
                        escalated  <= 1'b0;
                        busy       <= 1'b1;
                        buzzer     <= 1'b1;
                        timer      <= '0;
                        phase      <= '0;
                    end
                end
                S_NOTIFY: begin
                    phase  <= phase_nxt;
                    buzzer <= beep_nxt;
                    if (caregiver_clear) begin
                        state     <= S_CLEAR;
                        call_req  <= 1'b0;
                        clear_out <= 1'b1;
                        buzzer    <= 1'b0;
                    end else if (!alarm_in) begin
                        state      <= S_IDLE;
                        call_req   <= 1'b0;
                        call_level <= 2'd0;
                        escalated  <= 1'b0;
                        busy       <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (call_ack) begin
                        state    <= S_WAIT_CLEAR;
                        call_req <= 1'b0;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        state    <= S_ESCALATE;
                        call_req <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ESCALATE: begin
                    phase  <= phase_nxt;
                    buzzer <= beep_nxt;
                    if (caregiver_clear) begin
                        state     <= S_CLEAR;
                        clear_out <= 1'b1;
                        buzzer    <= 1'b0;
                    end else begin
                        // New request goes out already carrying the raised level.
                        state    <= S_NOTIFY;
                        call_req <= 1'b1;
                        timer    <= '0;
                        if (call_level < 2'(MAX_LEVEL))
                            call_level <= call_level + 1'b1;
                        else
                            escalated <= 1'b1;
                    end
                end
                S_WAIT_CLEAR: begin
                    phase  <= phase_nxt;
                    buzzer <= beep_nxt;
                    if (caregiver_clear) begin
                        state     <= S_CLEAR;
                        clear_out <= 1'b1;
                        buzzer    <= 1'b0;
                    end else if (!alarm_in) begin
                        state      <= S_IDLE;
                        call_level <= 2'd0;
                        escalated  <= 1'b0;
                        busy       <= 1'b0;
                        buzzer     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state      <= S_IDLE;
                    call_level <= 2'd0;
                    escalated  <= 1'b0;
                    busy       <= 1'b0;
                    buzzer     <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    call_req   <= 1'b0;
                    call_level <= 2'd0;
                    escalated  <= 1'b0;
                    busy       <= 1'b0;
                    buzzer     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FALL_RESP_COUNT_EN
    // call_req only rises when entering NOTIFY, so count those transitions directly.
    logic req_rise;

    always_comb begin
        req_rise = ((state == S_IDLE) && alarm_in) ||
                   ((state == S_ESCALATE) && !caregiver_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            call_count <= 8'd0;
        else if (req_rise && (call_count != 8'hFF))
            call_count <= call_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fall_alarm_responder.sv
// Directed bench for fall_alarm_responder: handshake, escalation, clear priority, buzzer pattern, reset.
module tb_fall_alarm_responder;

    logic       clk;
    logic       reset;
    logic       alarm_in;
    logic       call_ack;
    logic       caregiver_clear;
    logic       call_req;
    logic [1:0] call_level;
    logic       escalated;
    logic       buzzer;
    logic       clear_out;
    logic       busy;
`ifdef FALL_RESP_COUNT_EN
    logic [7:0] call_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fall_alarm_responder #(
        .ACK_TIMEOUT(16),
        .MAX_LEVEL  (3),
        .BEEP_ON    (4),
        .BEEP_OFF   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alarm_in       (alarm_in),
        .call_ack       (call_ack),
        .caregiver_clear(caregiver_clear),
        .call_req       (call_req),
        .call_level     (call_level),
        .escalated      (escalated),
        .buzzer         (buzzer),
        .clear_out      (clear_out),
        .busy           (busy)
`ifdef FALL_RESP_COUNT_EN
        ,
        .call_count     (call_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packed as {call_req, call_level[1:0], escalated, buzzer, clear_out, busy}.
    task automatic chk_out(input string tag, input logic e_req, input logic [1:0] e_lvl,
                           input logic e_esc, input logic e_buz, input logic e_clr,
                           input logic e_busy);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {call_req, call_level, escalated, buzzer, clear_out, busy};
        exp = {e_req, e_lvl, e_esc, e_buz, e_clr, e_busy};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed req/lvl/esc/buz/clr/busy=%b required %b", tag, obs, exp);
        end
    endtask

`ifdef FALL_RESP_COUNT_EN
    task automatic chk_cnt(input string tag, input logic [7:0] e_cnt);
        n_cmp++;
        assert (call_count === e_cnt)
        else begin
            n_fail++;
            $error("FAIL %s: observed call_count=%0d required %0d", tag, call_count, e_cnt);
        end
    endtask
`endif

    initial begin
        logic [1:0] lvl;

        reset           = 1'b1;
        alarm_in        = 1'b0;
        call_ack        = 1'b0;
        caregiver_clear = 1'b0;
        #3;
        chk_out("reset_state", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FALL_RESP_COUNT_EN
        chk_cnt("reset_count", 8'd0);
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_out("idle_after_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 1: alarm, ack after three request cycles, caregiver clear.
        alarm_in = 1'b1;
        tick();
        chk_out("t1_notify_entry", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("t1_req_c7", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("t1_req_c8", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        call_ack = 1'b1;
        tick();
        chk_out("t1_wait_clear_c9", 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        call_ack = 1'b0;
        tick();
        chk_out("t1_buzzer_low_c10", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        caregiver_clear = 1'b1;
        tick();
        chk_out("t1_clear_pulse_c13", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        caregiver_clear = 1'b0;
        tick();
        chk_out("t1_idle_c14", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 2 + 5: alarm still high re-arms; no ack, so escalate every 17 cycles with 4H/4L buzzer.
        tick();
        for (int i = 0; i < 86; i++) begin
            lvl = (i / 17 > 3) ? 2'd3 : 2'(i / 17);
            chk_out($sformatf("t2_cycle_%0d", i), ((i % 17) != 16), lvl, (i >= 68),
                    ((i % 8) < 4), 1'b0, 1'b1);
            if (i != 85) tick();
        end
`ifdef FALL_RESP_COUNT_EN
        chk_cnt("t2_count", 8'd7);
`endif

        // Test 6: asynchronous reset mid-NOTIFY.
        reset = 1'b1;
        #2;
        chk_out("t6_async_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FALL_RESP_COUNT_EN
        chk_cnt("t6_count_reset", 8'd0);
`endif
        alarm_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_out("t6_after_release", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 3: ack and clear together in NOTIFY, clear wins with a single pulse.
        alarm_in = 1'b1;
        tick();
        chk_out("t3_notify", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        call_ack        = 1'b1;
        caregiver_clear = 1'b1;
        tick();
        chk_out("t3_clear_wins", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        call_ack        = 1'b0;
        caregiver_clear = 1'b0;
        alarm_in        = 1'b0;
        tick();
        chk_out("t3_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t3_single_pulse", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 4: escalate once, ack, ack ignored in WAIT_CLEAR, alarm drop -> IDLE without pulse.
        alarm_in = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) tick();
        chk_out("t4_level1", 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        call_ack = 1'b1;
        tick();
        chk_out("t4_wait_clear", 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("t4_ack_ignored", 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        call_ack = 1'b0;
        alarm_in = 1'b0;
        tick();
        chk_out("t4_idle_no_pulse", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t4_still_no_pulse", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FALL_RESP_COUNT_EN
        chk_cnt("t4_count", 8'd3);
        for (int i = 0; i < 300; i++) begin
            alarm_in = 1'b1;
            tick();
            alarm_in = 1'b0;
            tick();
        end
        chk_cnt("count_saturate", 8'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
